// File: rtl/zuse_fp_pkg.sv
// Shared widths, limits and control-state encoding for the Z3-style adder.
package zuse_fp_pkg;
  localparam int EXP_W = 7;
  localparam int MAN_W = 15;
  localparam int EXP_MAX = 63;
  localparam logic [MAN_W-1:0] MAN_ONE = 15'h4000;
  localparam logic [MAN_W-1:0] MAN_MAX = 15'h7FFF;

  typedef enum logic [2:0] {
    IDLE,
    CMP,
    ALIGN,
    ADD,
    NORM
  } state_t;
endpackage

// File: rtl/zuse_fp_norm.sv
// Combinational normalise / optional round / overflow saturation for the NORM step.
// Rounding (half-up on the guard bit) is built only when ZUSE_FP_ROUND_EN is defined.
module zuse_fp_norm
  import zuse_fp_pkg::*;
(
  input  logic [MAN_W:0]   sum_i,
  input  logic [EXP_W-1:0] e_i,
`ifdef ZUSE_FP_ROUND_EN
  input  logic             g_i,
`endif
  output logic [MAN_W-1:0] m_o,
  output logic [EXP_W-1:0] e_o,
  output logic             ovf_o
);
  localparam logic signed [EXP_W+1:0] E_LIM = (EXP_W+2)'(EXP_MAX);

  // Two extra exponent bits so a double increment (carry then round carry) cannot wrap.
  logic signed [EXP_W+1:0] e_w;
  logic [MAN_W-1:0]        m_w;
`ifdef ZUSE_FP_ROUND_EN
  logic                    g_w;
  logic [MAN_W:0]          m_r;
`endif

  always_comb begin
    e_w = {{2{e_i[EXP_W-1]}}, e_i};
    m_w = sum_i[MAN_W-1:0];
`ifdef ZUSE_FP_ROUND_EN
    g_w = g_i;
    m_r = '0;
`endif
    if (sum_i[MAN_W]) begin
      m_w = sum_i[MAN_W:1];
      e_w = e_w + (EXP_W+2)'(1);
`ifdef ZUSE_FP_ROUND_EN
      g_w = sum_i[0];
`endif
    end
`ifdef ZUSE_FP_ROUND_EN
    m_r = {1'b0, m_w} + {{MAN_W{1'b0}}, g_w};
    if (m_r[MAN_W]) begin
      m_w = MAN_ONE;
      e_w = e_w + (EXP_W+2)'(1);
    end else begin
      m_w = m_r[MAN_W-1:0];
    end
`endif
    e_o   = e_w[EXP_W-1:0];
    m_o   = m_w;
    ovf_o = 1'b0;
    if (e_w > E_LIM) begin
      e_o   = EXP_W'(EXP_MAX);
      m_o   = MAN_MAX;
      ovf_o = 1'b1;
    end
  end
endmodule

// File: rtl/zuse_fp_adder.sv
// Multi-cycle adder of two positive floats: CMP, serial ALIGN (1 bit/cycle), ADD, NORM.
// Build option ZUSE_FP_ROUND_EN enables round half-up in NORM; latency is unchanged.
module zuse_fp_adder
  import zuse_fp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             add,
  input  logic [EXP_W-1:0] reg1_e,
  input  logic [MAN_W-1:0] reg1_m,
  input  logic [EXP_W-1:0] reg2_e,
  input  logic [MAN_W-1:0] reg2_m,
  output logic [EXP_W-1:0] res_e,
  output logic [MAN_W-1:0] res_m,
  output logic             idle,
  output logic             ovf
);
  state_t state_q, state_d;
  logic [EXP_W-1:0] ae_q, ae_d, be_q, be_d, le_q, le_d, res_e_q, res_e_d;
  logic [MAN_W-1:0] am_q, am_d, bm_q, bm_d, lm_q, lm_d, sm_q, sm_d, res_m_q, res_m_d;
  logic [MAN_W:0]   sum_q, sum_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
`ifdef ZUSE_FP_ROUND_EN
  logic             g_q, g_d;
`endif

  logic [EXP_W:0]   diff, kabs;
  logic [EXP_W-1:0] l_e, s_e, n_e;
  logic [MAN_W-1:0] l_m, s_m, n_m;
  logic [3:0]       k_w;
  logic             n_ovf;

  // Operand ordering: L gets the larger exponent; a zero L with a non-zero S is swapped
  // so the non-zero operand passes through unshifted.
  always_comb begin
    diff = {ae_q[EXP_W-1], ae_q} - {be_q[EXP_W-1], be_q};
    if (!diff[EXP_W]) begin
      l_e = ae_q; l_m = am_q; s_e = be_q; s_m = bm_q; kabs = diff;
    end else begin
      l_e = be_q; l_m = bm_q; s_e = ae_q; s_m = am_q; kabs = -diff;
    end
    if (l_m == '0 && s_m != '0) begin
      l_e = s_e; l_m = s_m; s_m = '0;
    end
    k_w = kabs[3:0];
    if (s_m == '0 || kabs >= (EXP_W+1)'(MAN_W)) begin
      s_m = '0; k_w = '0;
    end
  end

  zuse_fp_norm u_norm (
    .sum_i (sum_q),
    .e_i   (le_q),
`ifdef ZUSE_FP_ROUND_EN
    .g_i   (g_q),
`endif
    .m_o   (n_m),
    .e_o   (n_e),
    .ovf_o (n_ovf)
  );

  always_comb begin
    state_d = state_q;
    ae_d = ae_q; am_d = am_q; be_d = be_q; bm_d = bm_q;
    le_d = le_q; lm_d = lm_q; sm_d = sm_q; cnt_d = cnt_q; sum_d = sum_q;
    res_e_d = res_e_q; res_m_d = res_m_q; ovf_d = ovf_q;
`ifdef ZUSE_FP_ROUND_EN
    g_d = g_q;
`endif
    case (state_q)
      IDLE: if (add) begin
        ae_d = reg1_e; am_d = reg1_m; be_d = reg2_e; bm_d = reg2_m;
        ovf_d = 1'b0;
        state_d = CMP;
      end
      CMP: begin
        le_d = l_e; lm_d = l_m; sm_d = s_m; cnt_d = k_w;
`ifdef ZUSE_FP_ROUND_EN
        g_d = 1'b0;
`endif
        state_d = (k_w == '0) ? ADD : ALIGN;
      end
      ALIGN: begin
        sm_d  = sm_q >> 1;
        cnt_d = cnt_q - 4'd1;
`ifdef ZUSE_FP_ROUND_EN
        g_d = sm_q[0];
`endif
        if (cnt_q == 4'd1) state_d = ADD;
      end
      ADD: begin
        sum_d   = {1'b0, lm_q} + {1'b0, sm_q};
        state_d = NORM;
      end
      NORM: begin
        res_e_d = n_e; res_m_d = n_m; ovf_d = n_ovf;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ae_q <= '0; am_q <= '0; be_q <= '0; bm_q <= '0;
      le_q <= '0; lm_q <= '0; sm_q <= '0; cnt_q <= '0; sum_q <= '0;
      res_e_q <= '0; res_m_q <= '0; ovf_q <= 1'b0;
`ifdef ZUSE_FP_ROUND_EN
      g_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ae_q <= ae_d; am_q <= am_d; be_q <= be_d; bm_q <= bm_d;
      le_q <= le_d; lm_q <= lm_d; sm_q <= sm_d; cnt_q <= cnt_d; sum_q <= sum_d;
      res_e_q <= res_e_d; res_m_q <= res_m_d; ovf_q <= ovf_d;
`ifdef ZUSE_FP_ROUND_EN
      g_q <= g_d;
`endif
    end
  end

  assign idle  = (state_q == IDLE);
  assign res_e = res_e_q;
  assign res_m = res_m_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_zuse_fp_adder.sv
// Bench for zuse_fp_adder: directed corner cases plus random operands against an integer model.
module tb_zuse_fp_adder;
  logic        clk = 1'b0;
  logic        reset, add;
  logic [6:0]  reg1_e, reg2_e, res_e;
  logic [14:0] reg1_m, reg2_m, res_m;
  logic        idle, ovf;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  zuse_fp_adder dut (
    .clk(clk), .reset(reset), .add(add),
    .reg1_e(reg1_e), .reg1_m(reg1_m), .reg2_e(reg2_e), .reg2_m(reg2_m),
    .res_e(res_e), .res_m(res_m), .idle(idle), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  // Value model: align by integer shift, add, renormalise, saturate.
  function automatic void ref_add(input logic [6:0] ae, input logic [14:0] am,
                                  input logic [6:0] be, input logic [14:0] bm,
                                  output logic [6:0] re, output logic [14:0] rm,
                                  output logic rovf, output int lat);
    int ea, eb, le, se, lm, sm, k, sum, m, e;
`ifdef ZUSE_FP_ROUND_EN
    int g;
`endif
    ea = int'($signed(ae));
    eb = int'($signed(be));
    if (ea >= eb) begin le = ea; lm = int'(am); se = eb; sm = int'(bm); end
    else          begin le = eb; lm = int'(bm); se = ea; sm = int'(am); end
    k = le - se;
    if (lm == 0 && sm != 0) begin le = se; lm = sm; sm = 0; end
    if (sm == 0 || k >= 15) begin sm = 0; k = 0; end
    lat = 3 + k;
`ifdef ZUSE_FP_ROUND_EN
    g = (k > 0) ? ((sm >> (k - 1)) & 1) : 0;
`endif
    sum = lm + (sm >> k);
    e = le;
    if (sum >= 32768) begin
`ifdef ZUSE_FP_ROUND_EN
      g = sum & 1;
`endif
      m = sum >> 1;
      e++;
    end else begin
      m = sum;
    end
`ifdef ZUSE_FP_ROUND_EN
    m = m + g;
    if (m >= 32768) begin m = 16384; e++; end
`endif
    rovf = 1'b0;
    if (e > 63) begin e = 63; m = 32767; rovf = 1'b1; end
    re = 7'(e);
    rm = 15'(m);
  endfunction

  task automatic run_op(input logic [6:0] ae, input logic [14:0] am,
                        input logic [6:0] be, input logic [14:0] bm, input bit poke);
    logic [6:0]  re;
    logic [14:0] rm;
    logic        rovf;
    logic [31:0] e_pk;
    int exp_lat, lat;
    ref_add(ae, am, be, bm, re, rm, rovf, exp_lat);
    exp_q.push_back({9'd0, rovf, re, rm});
    @(negedge clk);
    reg1_e = ae; reg1_m = am; reg2_e = be; reg2_m = bm; add = 1'b1;
    @(negedge clk);
    add = 1'b0;
    lat = 0;
    while (idle == 1'b0 && lat < 300) begin
      lat++;
      if (poke && lat == 1) begin
        reg1_e = 7'($urandom); reg1_m = 15'($urandom);
        reg2_e = 7'($urandom); reg2_m = 15'($urandom);
        add = 1'b1;
      end else begin
        add = 1'b0;
      end
      @(negedge clk);
    end
    add = 1'b0;
    check("timeout", 32'(lat >= 300), 32'd0);
    check("latency", 32'(lat), 32'(exp_lat));
    e_pk = exp_q.pop_front();
    check("res_e", 32'(res_e), 32'(e_pk[21:15]));
    check("res_m", 32'(res_m), 32'(e_pk[14:0]));
    check("ovf", 32'(ovf), 32'(e_pk[22]));
  endtask

  task automatic check_hold(input logic [6:0] he, input logic [14:0] hm, input logic hovf);
    repeat (3) @(negedge clk);
    check("hold_e", 32'(res_e), 32'(he));
    check("hold_m", 32'(res_m), 32'(hm));
    check("hold_ovf", 32'(ovf), 32'(hovf));
    check("hold_idle", 32'(idle), 32'd1);
  endtask

  initial begin
    logic [6:0]  ae, be;
    logic [14:0] am, bm;
    reset = 1'b1; add = 1'b0;
    reg1_e = '0; reg1_m = '0; reg2_e = '0; reg2_m = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_e", 32'(res_e), 32'd0);
    check("rst_m", 32'(res_m), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    run_op(7'h00, 15'h4000, 7'h00, 15'h4000, 1'b0);
    check("one_plus_one_e", 32'(res_e), 32'd1);
    check("one_plus_one_m", 32'(res_m), 32'h4000);
    run_op(7'h00, 15'h4000, 7'h7F, 15'h4000, 1'b0);
    check("one_plus_half_m", 32'(res_m), 32'h6000);
    run_op(7'h7F, 15'h4000, 7'h00, 15'h4000, 1'b0);
    run_op(7'h20, 15'h4000, 7'h00, 15'h7FFF, 1'b0);
    run_op(7'h00, 15'h7FFF, 7'h20, 15'h4000, 1'b0);
    run_op(7'd63, 15'h4000, 7'd63, 15'h4000, 1'b0);
    check_hold(7'd63, 15'h7FFF, 1'b1);
    run_op(7'h00, 15'h4000, 7'h00, 15'h4000, 1'b0);
    run_op(7'h00, 15'h4001, 7'h00, 15'h4000, 1'b0);
    run_op(7'd5, 15'h0000, 7'd2, 15'h0000, 1'b0);
    run_op(7'd9, 15'h0000, 7'd1, 15'h5A5A, 1'b0);
    run_op(7'd10, 15'h5555, 7'd0, 15'h4000, 1'b1);
    check_hold(res_e, res_m, ovf);

    // Abort in the middle of alignment.
    @(negedge clk);
    reg1_e = 7'd10; reg1_m = 15'h4000; reg2_e = 7'd0; reg2_m = 15'h7FFF; add = 1'b1;
    @(negedge clk);
    add = 1'b0;
    repeat (2) @(negedge clk);
    check("align_busy", 32'(idle), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_idle", 32'(idle), 32'd1);
    check("abort_e", 32'(res_e), 32'd0);
    check("abort_m", 32'(res_m), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    run_op(7'd3, 15'h4321, 7'd1, 15'h6789, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ae = ($urandom_range(0, 3) == 0) ? 7'(63 - $urandom_range(0, 2)) : 7'($urandom);
      be = 7'(int'(ae) + $urandom_range(0, 36) - 18);
      case ($urandom_range(0, 7))
        0:       am = 15'h0;
        1, 2:    am = 15'($urandom);
        default: am = 15'(16384 + $urandom_range(0, 16383));
      endcase
      case ($urandom_range(0, 7))
        0:       bm = 15'h0;
        1:       bm = 15'($urandom);
        default: bm = 15'(16384 + $urandom_range(0, 16383));
      endcase
      run_op(ae, am, be, bm, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
